// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Single-port word memory that services one load/store request at a time,
//   inserting WAIT_CYCLES wait cycles between accept and the response strobe.
//
//   Parameters
//     DEPTH        number of 32-bit words (power of two, 4..1024)
//     WAIT_CYCLES  wait cycles between accept and response (0..15)
//
//   Ports
//     clk    in   clock, all state changes on rising edge
//     rst_n  in   asynchronous active-low reset
//     req    in   access request
//     rw     in   1 = store, 0 = load
//     addr   in   byte address; word index = addr[31:2]
//     wdata  in   store data
//     ready  out  request can be accepted this cycle (IDLE only)
//     ack    out  one-cycle response strobe
//     rdata  out  load data while ack=1, otherwise 0
//     err    out  access faulted (misaligned or out of range) while ack=1
module data_memory_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        rw_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH];

  logic          enter_resp;
  logic          cur_rw;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic          fault;
  logic [IW-1:0] idx;

  assign ready = (state == IDLE);

  // With WAIT_CYCLES=0 the RESP-entry edge is the accept edge itself, so the
  // transaction fields come straight from the inputs instead of the capture
  // registers; otherwise they always come from the captured copies.
  always_comb begin
    cur_rw     = rw_q;
    cur_addr   = addr_q;
    cur_wdata  = wdata_q;
    enter_resp = 1'b0;
    if (state == IDLE) begin
      cur_rw    = rw;
      cur_addr  = addr;
      cur_wdata = wdata;
      if (WAIT_CYCLES == 0) begin
        enter_resp = req;
      end
    end else if (state == WAIT) begin
      enter_resp = (cnt == 4'd1);
    end
    fault = (cur_addr[1:0] != 2'b00) || (cur_addr[31:2] >= 30'(DEPTH));
    // Index is truncated to the array width; a faulted access never uses it.
    idx   = cur_addr[IW+1:2];
  end

  // Memory shares the process so that a reset suppresses a pending commit;
  // the array itself is never reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;

      case (state)
        IDLE: begin
          if (req) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        ack <= 1'b1;
        err <= fault;
        if (!fault) begin
          if (cur_rw) begin
            mem[idx] <= cur_wdata;
          end else begin
            rdata <= mem[idx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req, rw, ready, ack, err;
  logic [31:0] addr, wdata, rdata;

  logic        req0, rw0, ready0, ack0, err0;
  logic [31:0] addr0, wdata0, rdata0;

  data_memory_responder #(.DEPTH(256), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .ready(ready), .ack(ack), .rdata(rdata), .err(err)
  );

  data_memory_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .rw(rw0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference memories: word arrays plus "has been written" flags.
  logic [31:0] mm  [256];
  bit          mv  [256];
  logic [31:0] mm0 [16];
  bit          mv0 [16];

  function automatic bit is_fault(input logic [31:0] a, input int unsigned depth);
    longint unsigned ua;
    ua = a;
    return (ua % 4 != 0) || (ua / 4 >= depth);
  endfunction

  // One transaction on the WAIT_CYCLES=2 instance; called at a negedge.
  task automatic txn(input logic r, input logic [31:0] a, input logic [31:0] d,
                     output logic got_err, output logic [31:0] got_rd);
    int n;
    int lat;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", 32'(ready), 32'd1);
    req = 1'b1; rw = r; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    // Inputs outside IDLE must be ignored; scribble on them.
    req = 1'b0; rw = 1'($urandom); addr = $urandom; wdata = $urandom;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      chk("ready_low_busy", 32'(ready), 32'd0);
      if (ack) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'(W + 1));
    got_err = err;
    got_rd  = rdata;
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack), 32'd0);
    chk("rdata_zero_idle", rdata, 32'd0);
    chk("err_zero_idle", 32'(err), 32'd0);
    chk("ready_after_resp", 32'(ready), 32'd1);
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic        e;
    logic [31:0] rd;
    logic [31:0] a;
    logic        r;
    logic [31:0] d;
    bit          f;
    int          lat;

    rst_n = 1'b0;
    req = 0; rw = 0; addr = '0; wdata = '0;
    req0 = 0; rw0 = 0; addr0 = '0; wdata0 = '0;
    foreach (mv[i]) mv[i] = 0;
    foreach (mv0[i]) mv0[i] = 0;

    #1;
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_ready0", 32'(ready0), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table: {rw, addr, wdata, exp_err, exp_rdata}
    tbl.push_back('{1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 32'h13,       32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF});
    tbl.push_back('{1'b1, 32'h0,        32'h11111111, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h400,      32'hCAFEF00D, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h0,        32'h0,        1'b0, 32'h11111111});
    tbl.push_back('{1'b1, 32'h20,       32'h1,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h14,       32'h14141414, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 32'h3FC,      32'hA5A55A5A, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 32'h3FC,      32'h0,        1'b0, 32'hA5A55A5A});
    tbl.push_back('{1'b0, 32'h3FE,      32'h0,        1'b1, 32'h0});
    tbl.push_back('{1'b1, 32'h3F9,      32'h77777777, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h14,       32'h0,        1'b0, 32'h14141414});
    tbl.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0});

    foreach (tbl[i]) begin
      txn(tbl[i].rw, tbl[i].addr, tbl[i].wdata, e, rd);
      chk($sformatf("tbl%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      if (!tbl[i].rw || tbl[i].exp_err)
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      if (tbl[i].rw && !tbl[i].exp_err) begin
        mm[tbl[i].addr / 4] = tbl[i].wdata;
        mv[tbl[i].addr / 4] = 1;
      end
    end

    // req held high with changing fields while busy: only the captured load is used.
    req = 1'b1; rw = 1'b0; addr = 32'h10; wdata = '0;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("hold_ready_low", 32'(ready), 32'd0);
      if (ack) begin
        lat = i;
        break;
      end
      rw = 1'b1; addr = 32'h14; wdata = 32'hBAD00000 + 32'(i);
    end
    chk("hold_latency", 32'(lat), 32'(W + 1));
    chk("hold_rdata", rdata, 32'hDEADBEEF);
    chk("hold_err", 32'(err), 32'd0);
    req = 1'b0;
    @(negedge clk);
    txn(1'b0, 32'h14, 32'h0, e, rd);
    chk("hold_no_store", rd, 32'h14141414);

    // Reset in WAIT of a store to 0x20 (holding 0x1): abandoned, no write.
    req = 1'b1; rw = 1'b1; addr = 32'h20; wdata = 32'h2;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("rst_mid_busy", 32'(ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_ack", 32'(ack), 32'd0);
    end
    rst_n = 1'b1;
    txn(1'b0, 32'h20, 32'h0, e, rd);
    chk("rst_load_err", 32'(e), 32'd0);
    chk("rst_store_dropped", rd, 32'h1);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0:       a = ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
        1:       a = $urandom_range(256, 1000000) << 2;
        default: a = $urandom_range(0, 31) << 2;
      endcase
      r = 1'($urandom);
      d = $urandom;
      f = is_fault(a, 256);
      txn(r, a, d, e, rd);
      chk("rnd_err", 32'(e), 32'(f));
      if (f) chk("rnd_fault_rdata", rd, 32'd0);
      else if (!r && mv[a / 4]) chk("rnd_rdata", rd, mm[a / 4]);
      if (r && !f) begin
        mm[a / 4] = d;
        mv[a / 4] = 1;
      end
    end

    // WAIT_CYCLES=0 instance, req held high: accept and ack alternate.
    req0 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k < 8) begin
        r = 1'b1; a = 32'(k) << 2;
      end else if (k < 16) begin
        r = 1'b0; a = 32'(k - 8) << 2;
      end else begin
        r = 1'($urandom);
        a = ($urandom_range(0, 4) == 0) ? (32'($urandom_range(0, 20)) << 2) | 32'($urandom_range(0, 1))
                                        : 32'($urandom_range(0, 15)) << 2;
      end
      d = $urandom;
      f = is_fault(a, 16);
      chk("w0_ready", 32'(ready0), 32'd1);
      chk("w0_idle_ack", 32'(ack0), 32'd0);
      rw0 = r; addr0 = a; wdata0 = d;
      @(negedge clk);
      chk("w0_ack", 32'(ack0), 32'd1);
      chk("w0_busy", 32'(ready0), 32'd0);
      chk("w0_err", 32'(err0), 32'(f));
      if (f) chk("w0_fault_rdata", rdata0, 32'd0);
      else if (!r && mv0[a / 4]) chk("w0_rdata", rdata0, mm0[a / 4]);
      if (r && !f) begin
        mm0[a / 4] = d;
        mv0[a / 4] = 1;
      end
      @(negedge clk);
    end
    req0 = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
